// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned NB_WORD     = 32;
  localparam int unsigned NB_PC       = 32;
  localparam int unsigned NB_MEM_IDX  = 8;

  localparam logic [NB_WORD-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NB_WORD-1:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [NB_PC-1:0]   PC_INC    = 32'd4;

  // Fetch stage control state.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction RAM: one write port, one read port. Writes land on the rising
// edge; the read port is a combinational look-up so that the IF/ID register in
// the fetch stage forms the synchronous read and sees the old word when a
// write hits the same index on the same edge.
module instruction_memory #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_MEM_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [NB_MEM_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0]     wr_data,
  input  logic [NB_MEM_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0]     rd_data_c
);

  localparam int unsigned DEPTH = 1 << NB_MEM_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Program-load write; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-through of the currently addressed word.
  always_comb begin
    rd_data_c = mem[rd_addr];
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches from instruction memory and drives the IF/ID
// register (instruction and PC+4). Handles stall, taken branch with one delay
// slot, debug freeze, and parks on NOPs once the HALT word is fetched.
module instruction_fetch #(
  parameter int unsigned NB_INSTRUCTIONS = mips_pkg::NB_WORD,
  parameter int unsigned NB_ADDRESS      = mips_pkg::NB_PC,
  parameter int unsigned NB_MEM_ADDR     = mips_pkg::NB_MEM_IDX,
  parameter logic [NB_INSTRUCTIONS-1:0] HALT_WORD = NB_INSTRUCTIONS'(mips_pkg::HALT_WORD)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_stall,
  input  logic                       i_branch,
  input  logic [NB_ADDRESS-1:0]      i_branch_addr,
  input  logic                       i_mem_wr_en,
  input  logic [NB_MEM_ADDR-1:0]     i_mem_wr_addr,
  input  logic [NB_INSTRUCTIONS-1:0] i_mem_wr_data,
  output logic [NB_INSTRUCTIONS-1:0] o_instruction,
  output logic [NB_ADDRESS-1:0]      o_pc,
  output logic                       o_halt,
  output logic [NB_ADDRESS-1:0]      o_pc_debug
);

  import mips_pkg::*;

  localparam logic [NB_INSTRUCTIONS-1:0] NOP    = NB_INSTRUCTIONS'(NOP_WORD);
  localparam logic [NB_ADDRESS-1:0]      INC    = NB_ADDRESS'(PC_INC);
  localparam logic [NB_ADDRESS-1:0]      PC_RST = '0;

  fetch_state_e                 state_q, state_d;
  logic [NB_ADDRESS-1:0]        pc_q, pc_d;
  logic [NB_INSTRUCTIONS-1:0]   instr_d;
  logic [NB_ADDRESS-1:0]        npc_d;
  logic                         halt_d;
  logic [NB_ADDRESS-1:0]        pc_plus4;
  logic [NB_INSTRUCTIONS-1:0]   rd_data;

  // Word-indexed fetch; byte offset bits are ignored and high bits wrap.
  instruction_memory #(
    .NB_DATA     (NB_INSTRUCTIONS),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) u_imem (
    .clk       (i_clk),
    .wr_en     (i_mem_wr_en),
    .wr_addr   (i_mem_wr_addr),
    .wr_data   (i_mem_wr_data),
    .rd_addr   (pc_q[NB_MEM_ADDR+1:2]),
    .rd_data_c (rd_data)
  );

  // Next-state, next-PC and IF/ID payload selection.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = o_instruction;
    npc_d    = o_pc;
    halt_d   = o_halt;
    pc_plus4 = pc_q + INC;

    if (i_enable) begin
      unique case (state_q)
        ST_RUN: begin
          // A stall wins over a branch; decode re-asserts the branch later.
          if (!i_stall) begin
            npc_d = pc_plus4;
            if (rd_data == HALT_WORD) begin
              // HALT never reaches decode; PC parks on the HALT address and
              // any branch sampled alongside it is dropped.
              instr_d = NOP;
              halt_d  = 1'b1;
              state_d = ST_HALTED;
            end else begin
              instr_d = rd_data;
              pc_d    = i_branch ? i_branch_addr : pc_plus4;
            end
          end
        end
        ST_HALTED: begin
          instr_d = NOP;
          halt_d  = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // PC, state and IF/ID register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= ST_RUN;
      pc_q          <= PC_RST;
      o_instruction <= NOP;
      o_pc          <= PC_RST;
      o_halt        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      o_instruction <= instr_d;
      o_pc          <= npc_d;
      o_halt        <= halt_d;
    end
  end

  // Current fetch address for the debug unit.
  always_comb begin
    o_pc_debug = pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table of per-cycle stimulus and
// expected IF/ID outputs, with expectations queued at drive time and checked
// after the edge.
module tb_instruction_fetch;

  localparam logic [31:0] H = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic        branch;
  logic [31:0] branch_addr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        halt;
  logic [31:0] pc_debug;

  instruction_fetch dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (enable),
    .i_stall       (stall),
    .i_branch      (branch),
    .i_branch_addr (branch_addr),
    .i_mem_wr_en   (wr_en),
    .i_mem_wr_addr (wr_addr),
    .i_mem_wr_data (wr_data),
    .o_instruction (instruction),
    .o_pc          (pc),
    .o_halt        (halt),
    .o_pc_debug    (pc_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        st;
    logic        br;
    logic [31:0] ba;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        chk_pc;
    logic        e_halt;
    logic [31:0] e_dbg;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        chk_pc;
    logic        e_halt;
    logic [31:0] e_dbg;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Preloaded program: word i holds 0x11*(i+1).
  function automatic logic [31:0] w(input int i);
    return 32'(i + 1) * 32'h11;
  endfunction

  function automatic vec_t mk(input logic r, input logic en, input logic st,
                              input logic br, input logic [31:0] ba,
                              input logic we, input logic [7:0] wa,
                              input logic [31:0] wd, input logic [31:0] ei,
                              input logic [31:0] ep, input logic cp,
                              input logic eh, input logic [31:0] ed);
    vec_t v;
    v.rst_n = r;  v.en = en;  v.st = st;  v.br = br;  v.ba = ba;
    v.we = we;    v.wa = wa;  v.wd = wd;
    v.e_instr = ei; v.e_pc = ep; v.chk_pc = cp; v.e_halt = eh; v.e_dbg = ed;
    return v;
  endfunction

  // Plain run cycle: enabled, no stall/branch/write.
  function automatic vec_t run(input logic [31:0] ei, input logic [31:0] ep,
                               input logic [31:0] ed);
    return mk(1, 1, 0, 0, 0, 0, 0, 0, ei, ep, 1, 0, ed);
  endfunction

  function automatic vec_t rst_v();
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, expv);
    end
  endtask

  initial begin
    rst_n = 0; enable = 1; stall = 0; branch = 0; branch_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;

    // Program load under reset: every word gets a known value.
    for (int i = 0; i < 256; i++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(i);
      wr_data = w(i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    // Reset state, then sequential fetch.
    vecs.push_back(rst_v());
    vecs.push_back(run(w(0), 32'd4,  32'd4));
    vecs.push_back(run(w(1), 32'd8,  32'd8));
    vecs.push_back(run(w(2), 32'd12, 32'd12));
    vecs.push_back(run(w(3), 32'd16, 32'd16));
    // Branch with delay slot.
    vecs.push_back(rst_v());
    vecs.push_back(run(w(0), 32'd4, 32'd4));
    vecs.push_back(run(w(1), 32'd8, 32'd8));
    vecs.push_back(mk(1, 1, 0, 1, 32'h20, 0, 0, 0, w(2), 32'd12, 1, 0, 32'h20));
    vecs.push_back(run(w(8), 32'h24, 32'h24));
    vecs.push_back(run(w(9), 32'h28, 32'h28));
    // Stall with branch: hold, then resume sequentially.
    vecs.push_back(mk(1, 1, 1, 1, 32'h40, 0, 0, 0, w(9), 32'h28, 1, 0, 32'h28));
    vecs.push_back(mk(1, 1, 1, 1, 32'h40, 0, 0, 0, w(9), 32'h28, 1, 0, 32'h28));
    vecs.push_back(run(w(10), 32'h2C, 32'h2C));
    // Freeze while loading word 11; a branch during freeze is ignored.
    vecs.push_back(mk(1, 0, 0, 0, 0,     1, 8'd11, 32'hABCD, w(10), 32'h2C, 1, 0, 32'h2C));
    vecs.push_back(mk(1, 0, 0, 1, 32'h80, 1, 8'd11, 32'hABCD, w(10), 32'h2C, 1, 0, 32'h2C));
    vecs.push_back(mk(1, 0, 0, 0, 0,     1, 8'd11, 32'hABCD, w(10), 32'h2C, 1, 0, 32'h2C));
    vecs.push_back(run(32'hABCD, 32'h30, 32'h30));
    // Write to the index being fetched returns the old word; branch back re-reads it.
    vecs.push_back(mk(1, 1, 0, 1, 32'h30, 1, 8'd12, 32'h1234, w(12), 32'h34, 1, 0, 32'h30));
    vecs.push_back(run(32'h1234, 32'h34, 32'h34));
    // PC wrap: fetch at 0xFFFFFFFC reads index 255, next PC is 0.
    vecs.push_back(mk(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, w(13), 32'h38, 1, 0, 32'hFFFF_FFFC));
    vecs.push_back(run(w(255), 32'h0, 32'h0));
    vecs.push_back(run(w(0), 32'd4, 32'd4));
    // HALT at word 3, loaded while in reset.
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'd3, H, 0, 0, 1, 0, 0));
    vecs.push_back(run(w(0), 32'd4,  32'd4));
    vecs.push_back(run(w(1), 32'd8,  32'd8));
    vecs.push_back(run(w(2), 32'd12, 32'd12));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd12));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1, (i != 7), (i % 3 == 1), (i % 2 == 0), 32'h20,
                        0, 0, 0, 0, 0, 0, 1, 32'd12));
    end
    // Reset from HALTED; program intact, HALT in the delay slot drops the target.
    vecs.push_back(rst_v());
    vecs.push_back(run(w(0), 32'd4,  32'd4));
    vecs.push_back(run(w(1), 32'd8,  32'd8));
    vecs.push_back(run(w(2), 32'd12, 32'd12));
    vecs.push_back(mk(1, 1, 0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 32'd12));
    vecs.push_back(mk(1, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 32'd12));
    // Reset mid-stall.
    vecs.push_back(rst_v());
    vecs.push_back(run(w(0), 32'd4, 32'd4));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, w(0), 32'd4, 1, 0, 32'd4));
    vecs.push_back(mk(0, 1, 1, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(run(w(0), 32'd4, 32'd4));

    for (int k = 0; k < vecs.size(); k++) begin
      exp_t e;
      rst_n       = vecs[k].rst_n;
      enable      = vecs[k].en;
      stall       = vecs[k].st;
      branch      = vecs[k].br;
      branch_addr = vecs[k].ba;
      wr_en       = vecs[k].we;
      wr_addr     = vecs[k].wa;
      wr_data     = vecs[k].wd;
      e.idx = k; e.e_instr = vecs[k].e_instr; e.e_pc = vecs[k].e_pc;
      e.chk_pc = vecs[k].chk_pc; e.e_halt = vecs[k].e_halt; e.e_dbg = vecs[k].e_dbg;
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard vec %0d: got empty queue expected entry", k);
      end else begin
        exp_t got;
        got = exp_q.pop_front();
        check("instruction", got.idx, instruction, got.e_instr);
        check("halt",        got.idx, 32'(halt),   32'(got.e_halt));
        check("pc_debug",    got.idx, pc_debug,    got.e_dbg);
        if (got.chk_pc) check("pc", got.idx, pc, got.e_pc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
